// File: rtl/strontium_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// CTRL bit positions and the fixed ID value.
package strontium_pkg;

  // MMIO word register select (byte address bits [3:2])
  localparam logic [1:0] RegCtrl    = 2'd0;
  localparam logic [1:0] RegCount   = 2'd1;
  localparam logic [1:0] RegCompare = 2'd2;
  localparam logic [1:0] RegId      = 2'd3;

  // CTRL bit indices
  localparam int unsigned CtrlEn     = 0;
  localparam int unsigned CtrlIrqEn  = 1;
  localparam int unsigned CtrlReload = 2;
  localparam int unsigned CtrlPend   = 3;
  localparam int unsigned CtrlFault  = 4;

  localparam logic [31:0] DMEM_ID = 32'h5372_0001;

endpackage

// File: rtl/dmem_mmio_timer.sv
// MMIO timer: CTRL/COUNT/COMPARE registers, compare-match logic and the
// interrupt handshake register. Build macro DMEM_FAULT_IRQ_EN adds the sticky
// FAULT bit fed by the top-level unmapped-access detector.
module dmem_mmio_timer
  import strontium_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpu_ena_i,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_sel_i,
  input  logic [31:0] wr_data_i,
  input  logic [1:0]  rd_sel_i,
  output logic [31:0] rd_data_o,
`ifdef DMEM_FAULT_IRQ_EN
  input  logic        fault_evt_i,
`endif
  output logic        irq_o
);

  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        reload_q, reload_d;
  logic        pend_q, pend_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        irq_q, irq_d;
  logic        match;
  logic        fault_evt;
  logic        wr_ctrl;

`ifdef DMEM_FAULT_IRQ_EN
  assign fault_evt = fault_evt_i;
`else
  assign fault_evt = 1'b0;
`endif

  assign wr_ctrl = wr_en_i && (wr_sel_i == RegCtrl);
  // Match uses pre-edge register values only
  assign match   = en_q && cpu_ena_i && (count_q == compare_q);

  // Next-state for all timer registers
  always_comb begin
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    reload_d  = reload_q;
    pend_d    = pend_q;
    fault_d   = fault_q;
    count_d   = count_q;
    compare_d = compare_q;
    irq_d     = irq_q;

    if (wr_ctrl) begin
      en_d     = wr_data_i[CtrlEn];
      irq_en_d = wr_data_i[CtrlIrqEn];
      reload_d = wr_data_i[CtrlReload];
      if (wr_data_i[CtrlPend]) pend_d = 1'b0;
      if (wr_data_i[CtrlFault]) fault_d = 1'b0;
    end
    // Set events are applied after W1C so they win
    if (match) pend_d = 1'b1;
    if (fault_evt) fault_d = 1'b1;

    // CPU write to COUNT beats reload and increment
    if (wr_en_i && (wr_sel_i == RegCount)) begin
      count_d = wr_data_i;
    end else if (match && reload_q) begin
      count_d = '0;
    end else if (en_q && cpu_ena_i) begin
      count_d = count_q + 32'd1;
    end

    if (wr_en_i && (wr_sel_i == RegCompare)) compare_d = wr_data_i;

    // Handshake: drop after one cycle seen high with the core enabled
    if (irq_q && cpu_ena_i) irq_d = 1'b0;
    if ((match && irq_en_q) || fault_evt) irq_d = 1'b1;
  end

  // Timer state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      reload_q  <= 1'b0;
      pend_q    <= 1'b0;
      fault_q   <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      reload_q  <= reload_d;
      pend_q    <= pend_d;
      fault_q   <= fault_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
    end
  end

  // Register read mux
  always_comb begin
    rd_data_o = '0;
    unique case (rd_sel_i)
      RegCtrl:    rd_data_o = {27'b0, fault_q, pend_q, reload_q, irq_en_q, en_q};
      RegCount:   rd_data_o = count_q;
      RegCompare: rd_data_o = compare_q;
      RegId:      rd_data_o = DMEM_ID;
      default:    rd_data_o = '0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, address decode and read mux, plus the MMIO
// timer. Combinational reads on fetch_DMEM_addr, synchronous writes on
// DMEM_addr. Build macro DMEM_FAULT_IRQ_EN flags unmapped accesses as faults.
module dmem_responder
  import strontium_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] RAM_BASE   = 32'h1001_0000,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ena,
  input  logic [31:0] DMEM_addr,
  input  logic [31:0] DMEM_wdata,
  input  logic        DMEM_we,
  input  logic [31:0] fetch_DMEM_addr,
  output logic [31:0] DMEM_rdata,
  output logic        out_interruption
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [31:0] mem_q [Depth];
  logic        wr_ram_hit, wr_mmio_hit;
  logic        rd_ram_hit, rd_mmio_hit;
  logic [31:0] mmio_rdata;
  logic        unused_byte_bits;

  // Byte offset bits are ignored for word-granular accesses
  assign unused_byte_bits = ^{DMEM_addr[1:0], fetch_DMEM_addr[1:0]};

  assign wr_ram_hit  = DMEM_addr[31:ADDR_WIDTH+2] == RAM_BASE[31:ADDR_WIDTH+2];
  assign rd_ram_hit  = fetch_DMEM_addr[31:ADDR_WIDTH+2] == RAM_BASE[31:ADDR_WIDTH+2];
  assign wr_mmio_hit = DMEM_addr[31:4] == MMIO_BASE[31:4];
  assign rd_mmio_hit = fetch_DMEM_addr[31:4] == MMIO_BASE[31:4];

  // RAM write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (DMEM_we && wr_ram_hit) begin
      mem_q[DMEM_addr[ADDR_WIDTH+1:2]] <= DMEM_wdata;
    end
  end

`ifdef DMEM_FAULT_IRQ_EN
  logic fault_evt;
  // Unmapped fetch only counts while the core is running
  assign fault_evt = (cpu_ena && !rd_ram_hit && !rd_mmio_hit) ||
                     (DMEM_we && !wr_ram_hit && !wr_mmio_hit);
`endif

  dmem_mmio_timer u_timer (
    .clk_i       (clk),
    .reset_i     (reset),
    .cpu_ena_i   (cpu_ena),
    .wr_en_i     (DMEM_we && wr_mmio_hit),
    .wr_sel_i    (DMEM_addr[3:2]),
    .wr_data_i   (DMEM_wdata),
    .rd_sel_i    (fetch_DMEM_addr[3:2]),
    .rd_data_o   (mmio_rdata),
`ifdef DMEM_FAULT_IRQ_EN
    .fault_evt_i (fault_evt),
`endif
    .irq_o       (out_interruption)
  );

  // Read mux; reads see pre-edge RAM contents, so same-cycle writes return old data
  always_comb begin
    DMEM_rdata = '0;
    if (rd_ram_hit) begin
      DMEM_rdata = mem_q[fetch_DMEM_addr[ADDR_WIDTH+1:2]];
    end else if (rd_mmio_hit) begin
      DMEM_rdata = mmio_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM read/write ordering, timer match and
// reload, IRQ handshake, COUNT wrap and write precedence, unmapped accesses, reset.
module tb_dmem_responder;

  localparam logic [31:0] Mmio     = 32'hFFFF_0000;
  localparam logic [31:0] ACtrl    = Mmio + 32'h0;
  localparam logic [31:0] ACount   = Mmio + 32'h4;
  localparam logic [31:0] ACompare = Mmio + 32'h8;
  localparam logic [31:0] AId      = Mmio + 32'hC;
  localparam logic [31:0] AIdle    = 32'h1001_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ena;
  logic [31:0] DMEM_addr;
  logic [31:0] DMEM_wdata;
  logic        DMEM_we;
  logic [31:0] fetch_DMEM_addr;
  logic [31:0] DMEM_rdata;
  logic        out_interruption;

  int checks = 0;
  int errors = 0;

  dmem_responder dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_ena          (cpu_ena),
    .DMEM_addr        (DMEM_addr),
    .DMEM_wdata       (DMEM_wdata),
    .DMEM_we          (DMEM_we),
    .fetch_DMEM_addr  (fetch_DMEM_addr),
    .DMEM_rdata       (DMEM_rdata),
    .out_interruption (out_interruption)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    DMEM_addr  = a;
    DMEM_wdata = d;
    DMEM_we    = 1'b1;
    tick();
    DMEM_we    = 1'b0;
    DMEM_addr  = AIdle;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    fetch_DMEM_addr = a;
    #1;
    check(tag, DMEM_rdata, e);
    fetch_DMEM_addr = AIdle;
  endtask

  task automatic chk_irq(input string tag, input logic e);
    check(tag, {31'b0, out_interruption}, {31'b0, e});
  endtask

  initial begin
    reset = 1'b1;
    cpu_ena = 1'b0;
    DMEM_addr = AIdle;
    DMEM_wdata = '0;
    DMEM_we = 1'b0;
    fetch_DMEM_addr = AIdle;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk_irq("rst_irq", 1'b0);
    rd("rst_ctrl", ACtrl, 32'h0);
    rd("rst_count", ACount, 32'h0);
    rd("rst_compare", ACompare, 32'h0);
    rd("id", AId, 32'h5372_0001);
    wr(AId, 32'h1234_5678);
    rd("id_ro", AId, 32'h5372_0001);

    // 1. RAM write then read, byte offset ignored
    wr(32'h1001_0004, 32'hDEAD_BEEF);
    rd("ram_rd", 32'h1001_0004, 32'hDEAD_BEEF);
    rd("ram_rd_off", 32'h1001_0007, 32'hDEAD_BEEF);

    // 2. Same-cycle write and read returns old data
    wr(32'h1001_0008, 32'h0);
    DMEM_addr = 32'h1001_0008;
    DMEM_wdata = 32'h1;
    DMEM_we = 1'b1;
    rd("raw_old", 32'h1001_0008, 32'h0);
    tick();
    DMEM_we = 1'b0;
    rd("raw_new", 32'h1001_0008, 32'h1);

    // 3. Periodic match with reload
    cpu_ena = 1'b1;
    wr(ACompare, 32'd5);
    wr(ACount, 32'd0);
    wr(ACtrl, 32'h7);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_irq("t3_irq_low", 1'b0);
    end
    rd("t3_count5", ACount, 32'd5);
    tick();
    chk_irq("t3_irq_high", 1'b1);
    rd("t3_pend", ACtrl, 32'hF);
    rd("t3_reload", ACount, 32'd0);
    tick();
    chk_irq("t3_irq_drop", 1'b0);
    rd("t3_count1", ACount, 32'd1);
    wr(ACtrl, 32'h8);
    rd("t3_clear", ACtrl, 32'h0);

    // 4. IRQ held while core is stalled
    wr(ACount, 32'd0);
    wr(ACtrl, 32'h7);
    for (int i = 0; i < 6; i++) tick();
    chk_irq("t4_irq_high", 1'b1);
    cpu_ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_irq("t4_irq_hold", 1'b1);
    end
    cpu_ena = 1'b1;
    #1;
    chk_irq("t4_irq_still", 1'b1);
    tick();
    chk_irq("t4_irq_drop", 1'b0);
    wr(ACtrl, 32'h8);
    rd("t4_clear", ACtrl, 32'h0);

    // 5. Wrap and COUNT write precedence
    wr(ACount, 32'hFFFF_FFFF);
    wr(ACtrl, 32'h1);
    rd("t5_max", ACount, 32'hFFFF_FFFF);
    tick();
    rd("t5_wrap", ACount, 32'h0);
    wr(ACount, 32'h100);
    rd("t5_wr_wins", ACount, 32'h100);
    tick();
    rd("t5_inc", ACount, 32'h101);
    wr(ACtrl, 32'h0);

    // Match beats same-cycle PEND clear
    wr(ACompare, 32'd3);
    wr(ACount, 32'd3);
    wr(ACtrl, 32'h1);
    wr(ACtrl, 32'h9);
    rd("pend_wins", ACtrl, 32'h9);
    chk_irq("pend_no_irq", 1'b0);
    wr(ACtrl, 32'h8);
    rd("pend_clr", ACtrl, 32'h0);

    // 6. Unmapped read
    fetch_DMEM_addr = 32'h0000_0040;
    #1;
    check("unmapped_rd", DMEM_rdata, 32'h0);
    tick();
    fetch_DMEM_addr = AIdle;
`ifdef DMEM_FAULT_IRQ_EN
    chk_irq("fault_irq", 1'b1);
    rd("fault_set", ACtrl, 32'h10);
    tick();
    chk_irq("fault_irq_drop", 1'b0);
    wr(ACtrl, 32'h10);
    rd("fault_clr", ACtrl, 32'h0);
`else
    chk_irq("nofault_irq", 1'b0);
    rd("nofault_ctrl", ACtrl, 32'h0);
`endif

    // Reset mid-count with a pending IRQ
    wr(ACompare, 32'd2);
    wr(ACount, 32'd2);
    wr(ACtrl, 32'h3);
    tick();
    chk_irq("pre_rst_irq", 1'b1);
    cpu_ena = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_irq("rst2_irq", 1'b0);
    rd("rst2_ctrl", ACtrl, 32'h0);
    rd("rst2_count", ACount, 32'h0);
    rd("rst2_compare", ACompare, 32'h0);
    rd("rst2_ram_kept", 32'h1001_0004, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
